// File: rtl/data_mem.sv
// data_mem: single-outstanding load/store responder for the RV32I memory stage.
// Requests are latched in IDLE, held for WAIT_CYCLES extra cycles, then
// answered from RESP until the consumer accepts. Byte lanes are little-endian.
module data_mem #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam bit         ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0] CNT_INIT  = ZERO_WAIT ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Storage is deliberately not reset so contents survive a reset pulse.
    logic [31:0] mem_q [DEPTH_WORDS];

    // Operands of the access being performed: live request on a zero-wait
    // accept, otherwise the fields latched at the handshake.
    logic          a_sel_in_s;
    logic          a_we_s;
    logic [31:0]   a_addr_s;
    logic [1:0]    a_size_s;
    logic          a_uns_s;
    logic [31:0]   a_wdata_s;
    logic          a_err_s;
    logic [AW-1:0] a_idx_s;
    logic [3:0]    a_be_s;
    logic [31:0]   a_lanes_s;
    logic [31:0]   rd_word_s;
    logic          do_access_s;
    logic          do_write_s;

    // Misaligned, illegal size, or beyond the last word.
    function automatic logic access_err(input logic [31:0] addr, input logic [1:0] size);
        logic e;
        case (size)
            2'b00:   e = 1'b0;
            2'b01:   e = addr[0];
            2'b10:   e = (addr[1:0] != 2'b00);
            default: e = 1'b1;
        endcase
        return e | ({2'b00, addr[31:2]} >= 32'(DEPTH_WORDS));
    endfunction

    // Byte enables for a store of the given size at the given lane offset.
    function automatic logic [3:0] byte_en(input logic [1:0] off, input logic [1:0] size);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-justified store data across lanes; byte_en picks the lanes.
    function automatic logic [31:0] store_lanes(input logic [31:0] wdata, input logic [1:0] size);
        logic [31:0] d;
        case (size)
            2'b00:   d = {4{wdata[7:0]}};
            2'b01:   d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    // Extract the addressed byte/half and sign- or zero-extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {off, 3'b000});
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            2'b10:   r = word;
            default: r = 32'h00000000;
        endcase
        return r;
    endfunction

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    assign a_sel_in_s = (state_q == ST_IDLE);
    assign a_we_s     = a_sel_in_s ? req_we       : we_q;
    assign a_addr_s   = a_sel_in_s ? req_addr     : addr_q;
    assign a_size_s   = a_sel_in_s ? req_size     : size_q;
    assign a_uns_s    = a_sel_in_s ? req_unsigned : uns_q;
    assign a_wdata_s  = a_sel_in_s ? req_wdata    : wdata_q;
    assign a_err_s    = access_err(a_addr_s, a_size_s);
    assign a_idx_s    = a_addr_s[AW+1:2];
    assign a_be_s     = byte_en(a_addr_s[1:0], a_size_s);
    assign a_lanes_s  = store_lanes(a_wdata_s, a_size_s);
    assign rd_word_s  = mem_q[a_idx_s];

    assign do_access_s = (ZERO_WAIT && (state_q == ST_IDLE) && req_valid) ||
                         ((state_q == ST_WAIT) && (cnt_q == 4'd0));
    assign do_write_s  = do_access_s && a_we_s && !a_err_s;

    // Next-state, request latch and response data computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        if (do_access_s) begin
            err_d   = a_err_s;
            rdata_d = (a_err_s || a_we_s) ? 32'h00000000
                                          : load_extract(rd_word_s, a_addr_s[1:0], a_size_s, a_uns_s);
        end else begin
            err_d   = err_q;
            rdata_d = rdata_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (ZERO_WAIT) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and response registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'h00000000;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            wdata_q <= 32'h00000000;
            rdata_q <= 32'h00000000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte-lane merge into the array when a good store is performed.
    always_ff @(posedge clk) begin
        if (do_write_s) begin
            for (int i = 0; i < 4; i++) begin
                if (a_be_s[i]) begin
                    mem_q[a_idx_s][8*i +: 8] <= a_lanes_s[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: doc/data_mem.md
# data_mem

Data-memory responder for the RISC-V core: the slave end of the load/store request/response handshake the CPU's memory stage will drive. It accepts one byte-addressed load or store at a time and applies a programmable number of wait states. Store data is merged into the addressed byte lanes (little-endian). Load data is returned sign- or zero-extended according to the RV32I size/unsigned encoding (funct3).

## Interface
Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1
- WAIT_CYCLES, 1: extra wait states per access (0..15)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_size  in  2  funct3[1:0]: 00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  funct3[2]: zero-extend loads; ignored for word and for stores
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned, illegal size, or out-of-range access

## Operation
- State machine IDLE -> WAIT -> RESP -> IDLE.
- IDLE: req_ready=1. Request handshake when req_valid && req_ready at edge E0. All request fields are latched at E0.
  - WAIT_CYCLES=0: the access is performed at E0 and the next state is RESP.
  - Otherwise: the next state is WAIT, with the counter set to WAIT_CYCLES-1.
- WAIT: at each edge, if the counter is 0, perform the access and go to RESP; otherwise decrement the counter.
- RESP: resp_valid=1, with resp_rdata and resp_err held stable. When resp_valid && resp_ready at an edge, the next state is IDLE and resp_valid drops.
- Error conditions:
  - size 11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr[31:2] >= DEPTH_WORDS.
- On error: no array write, resp_rdata=0, resp_err=1, same latency as a good access.
- Store: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0]; word writes all 4 lanes. Untouched lanes keep their contents.
- Load: byte/half extracted from the same lanes, then sign-extended from bit 7/15, or zero-extended if req_unsigned.
- Memory array is not reset; contents survive reset.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter 0.
- Latency: resp_valid first high in the cycle after edge E0+WAIT_CYCLES, i.e. WAIT_CYCLES+1 cycles after the request cycle.
- Throughput: one access per WAIT_CYCLES+2 cycles when resp_ready is held high; req_ready is low from E0 until the response handshake edge.
- A new request is never accepted in the same cycle as a response handshake; req_ready returns high the cycle after.
- Backpressure: resp_ready low holds RESP indefinitely, with outputs unchanged.
- Reset mid-operation:
  - a store still in WAIT is dropped, with no array write;
  - a store already performed (state RESP) persists;
  - all outputs return to reset values immediately (asynchronous).
- req_* inputs are ignored outside IDLE.

## Test plan
- Reset then idle: assert reset mid-cycle -> resp_valid=0, resp_rdata=0, resp_err=0, req_ready=1 asynchronously; req_ready stays 1.
- Word store/load, WAIT_CYCLES=1: store 0xDEADBEEF at 0x10 -> resp_valid 2 cycles after the request cycle with err=0, rdata=0; load 0x10 -> rdata 0xDEADBEEF.
- Sub-word merge and extension: word 0x11223344 at 0x20; store byte 0x80 at 0x21 -> word reads 0x11228044; lb 0x21 -> 0xFFFFFF80; lbu 0x21 -> 0x00000080; lh 0x22 -> 0x00001122.
- Errors: lw 0x23 -> err=1, rdata=0; sh 0x25 -> err=1 and the word at 0x24 is unchanged; size 11 -> err=1; lw at 4*DEPTH_WORDS -> err=1.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP -> resp_valid and rdata stable, req_ready=0; raise resp_ready -> IDLE next cycle.
- Reset mid-WAIT with WAIT_CYCLES=3: store 0xCAFEF00D at 0x40 over prior 0x12345678, reset one cycle after E0 -> subsequent load returns 0x12345678.
